// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
//   Shared types and constants for the instruction fetch front-end.
//   word          : 32-bit machine word (addresses and instructions)
//   branch_en_t   : redirect qualifier driven by the execute stage
//   INST_BYTES    : byte stride between consecutive instructions
//   ALIGN_MASK    : clears the byte-offset bits of a word address
//   next_pc()     : sequential successor of a word address (32-bit wrap)
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

    typedef logic [31:0] word;

    typedef enum logic {
        BRANCH_DISABLE = 1'b0,
        BRANCH_ENABLE  = 1'b1
    } branch_en_t;

    localparam int unsigned INST_BYTES = 4;
    localparam word         ALIGN_MASK = 32'hFFFF_FFFC;

    // Sequential successor; the 32-bit add wraps 32'hFFFF_FFFC to 32'h0.
    function automatic word next_pc(input word pc);
        return pc + word'(INST_BYTES);
    endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock in-order FIFO with synchronous reset and synchronous clear.
//   Head data is presented combinationally; a push into a full FIFO is only
//   accepted together with a pop, and a pop of an empty FIFO is ignored.
//   Ports:
//     clk, rst     : clock, synchronous active-high reset
//     clr          : synchronous flush, overrides push and pop
//     push, push_data
//     pop, pop_data: pop_data is the current head entry
//     empty        : no valid entry
//     count        : number of valid entries (0..DEPTH)
//   Parameters: WIDTH (entry bits), DEPTH (entries, power of two, >= 2)
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_s;
    logic             empty_s;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_s  = (count_q == '0);
    assign full_s   = (count_q == CW'(DEPTH));
    assign empty    = empty_s;
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state; clear wins over any push or pop.
    always_comb begin
        do_pop_s  = pop && !empty_s;
        // A full FIFO can still take a push when the head leaves this cycle.
        do_push_s = push && (!full_s || do_pop_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CW'(do_push_s) - CW'(do_pop_s);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because count gates validity.
    always_ff @(posedge clk) begin
        if (!rst && !clr && do_push_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   PC generator and instruction fetcher. Issues sequential word fetches,
//   buffers in-order responses in a FIFO for decode, and handles execute-stage
//   redirects by flushing the buffer and dropping stale in-flight responses.
//   Ports:
//     clk, rst                       : clock, synchronous active-high reset
//     branch_scs, branch_address     : redirect request and target
//     imem_req_valid/ready/addr      : fetch request channel (non-sticky)
//     imem_rsp_valid/data            : in-order responses, no backpressure
//     inst_valid/ready, inst, inst_pc: decode-facing FIFO head
//     fetch_misaligned               : sticky misaligned-target halt flag
//                                      (only with FETCH_MISALIGN_TRAP_EN)
//   Build option FETCH_MISALIGN_TRAP_EN: a redirect to a non-word-aligned
//   target halts issue until reset instead of silently aligning the target.
//   Parameters: RESET_PC (first fetch address), FIFO_DEPTH (buffer entries,
//   power of two >= 2, also caps buffered plus in-flight fetches).
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter word         RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  branch_en_t  branch_scs,
    input  word         branch_address,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output word         imem_req_addr,
    input  logic        imem_rsp_valid,
    input  word         imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output word         inst,
    output word         inst_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        fetch_misaligned
`endif
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    word             fetch_pc_q, fetch_pc_d;
    word             rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]   fifo_count_s;
    logic [CW:0]     occupancy_s;
    logic            fifo_empty_s;
    logic [63:0]     fifo_head_s;
    logic            req_valid_s;
    logic            req_fire_s;
    logic            rsp_fire_s;
    logic            redirect_s;
    logic            push_s;
    logic            pop_s;
    word             target_s;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            halt_q, halt_d;
    logic            misalign_s;
`endif

    // Issue eligibility: buffered plus outstanding fetches must stay below the
    // FIFO depth so every response is guaranteed a free slot.
    always_comb begin
        occupancy_s = {1'b0, fifo_count_s} + {1'b0, inflight_q};
`ifdef FETCH_MISALIGN_TRAP_EN
        req_valid_s = !rst && !halt_q && (occupancy_s < (CW+1)'(FIFO_DEPTH));
`else
        req_valid_s = !rst && (occupancy_s < (CW+1)'(FIFO_DEPTH));
`endif
        req_fire_s  = req_valid_s && imem_req_ready;
        rsp_fire_s  = imem_rsp_valid;
        redirect_s  = (branch_scs == BRANCH_ENABLE);
    end

    // Redirect target: kept raw when misalignment traps, otherwise forced to a
    // word boundary so the PC counters never leave word alignment.
    always_comb begin
`ifdef FETCH_MISALIGN_TRAP_EN
        target_s   = branch_address;
        misalign_s = redirect_s && (branch_address[1:0] != 2'b00);
`else
        target_s   = branch_address & ALIGN_MASK;
`endif
    end

    // Counter next-state. A redirect overrides everything: every request still
    // outstanding after this cycle (including one accepted right now) is stale,
    // and a response arriving right now is discarded.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        drop_cnt_d = drop_cnt_q;
        push_s     = 1'b0;
        inflight_d = inflight_q + CW'(req_fire_s) - CW'(rsp_fire_s);
`ifdef FETCH_MISALIGN_TRAP_EN
        halt_d     = halt_q;
`endif
        if (redirect_s) begin
            fetch_pc_d = target_s;
            rsp_pc_d   = target_s;
            drop_cnt_d = inflight_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            halt_d     = halt_q || misalign_s;
`endif
        end else begin
            if (req_fire_s) begin
                fetch_pc_d = next_pc(fetch_pc_q);
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (rsp_fire_s) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - CW'(1);
                end else begin
                    push_s   = 1'b1;
                    rsp_pc_d = next_pc(rsp_pc_q);
                end
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
        end
    end

    // Fetch-state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            halt_q     <= 1'b0;
`endif
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            halt_q     <= halt_d;
`endif
        end
    end

    assign pop_s = !fifo_empty_s && inst_ready && !redirect_s;

    sync_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (redirect_s),
        .push      (push_s),
        .push_data ({rsp_pc_q, imem_rsp_data}),
        .pop       (pop_s),
        .pop_data  (fifo_head_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // Output drive; data buses read zero whenever their valid is low.
    always_comb begin
        imem_req_valid = req_valid_s;
        inst_valid     = !fifo_empty_s;
        if (req_valid_s) begin
            imem_req_addr = fetch_pc_q;
        end else begin
            imem_req_addr = 32'h0000_0000;
        end
        if (!fifo_empty_s) begin
            inst    = fifo_head_s[31:0];
            inst_pc = fifo_head_s[63:32];
        end else begin
            inst    = 32'h0000_0000;
            inst_pc = 32'h0000_0000;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    assign fetch_misaligned = halt_q;
`endif

endmodule
